// File: rtl/fir_pkg.sv
// Shared definitions for the multichannel FIR engine: FSM state encoding and a
// width helper used to size tag and tap-index ports.
package fir_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } fir_state_e;

   // ceil(log2(n)), never less than 1 so a single-entry field still has a bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/fir_tap_ram.sv
// One channel's N_TAP-deep sample history as a circular buffer; x[0] is the
// newest sample and rd_idx selects x[k] for the shared MAC.
module fir_tap_ram
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int N_TAP  = 8
) (
   input  logic                          clk_filter,
   input  logic                          rst,
   input  logic                          push,
   input  logic [DATA_W-1:0]             push_data,
   input  logic [clog2_min1(N_TAP)-1:0]  rd_idx,
   output logic [DATA_W-1:0]             rd_data
);

   localparam int TAP_W = clog2_min1(N_TAP);

   logic [N_TAP-1:0][DATA_W-1:0] mem;
   logic [TAP_W-1:0]             head;
   logic [TAP_W-1:0]             head_nxt;
   logic [TAP_W:0]               rd_sum;
   logic [TAP_W-1:0]             rd_addr;

   // head walks downward so x[k] lives at head+k (mod N_TAP); no data moves
   assign head_nxt = (head == '0) ? TAP_W'(N_TAP - 1) : head - TAP_W'(1);

   always_comb begin
      rd_sum  = {1'b0, head} + {1'b0, rd_idx};
      rd_addr = (rd_sum >= (TAP_W+1)'(N_TAP)) ? TAP_W'(rd_sum - (TAP_W+1)'(N_TAP))
                                              : rd_sum[TAP_W-1:0];
   end

   assign rd_data = mem[rd_addr];

   always_ff @(posedge clk_filter) begin
      if (rst) begin
         mem  <= '0;
         head <= '0;
      end else if (push) begin
         head          <= head_nxt;
         mem[head_nxt] <= push_data;
      end
   end

endmodule

// File: rtl/multichannel_fir_engine.sv
// Time-multiplexed FIR: one multiplier-accumulator serves N_CH interleaved channels
// with shared coefficients. Define FIR_ROUND_SAT_EN for rounded, saturated output.
module multichannel_fir_engine
   import fir_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int COEF_W = 16,
   parameter int N_TAP  = 8,
   parameter int N_CH   = 4,
   parameter int SHIFT  = 15
) (
   input  logic                          clk_filter,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [clog2_min1(N_CH)-1:0]   in_ch,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          coef_we,
   input  logic [clog2_min1(N_TAP)-1:0]  coef_addr,
   input  logic [COEF_W-1:0]             coef_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [clog2_min1(N_CH)-1:0]   out_ch,
   output logic [DATA_W-1:0]             out_data,
   output logic                          ch_err
);

   localparam int CH_W   = clog2_min1(N_CH);
   localparam int TAP_W  = clog2_min1(N_TAP);
   localparam int PROD_W = DATA_W + COEF_W;
   localparam int ACC_W  = PROD_W + TAP_W;

   fir_state_e                   state, state_nxt;
   logic [CH_W-1:0]              cur_ch;
   logic [TAP_W-1:0]             tap_idx;
   logic signed [ACC_W-1:0]      acc, acc_nxt;
   logic [N_TAP-1:0][COEF_W-1:0] coef;
   logic [N_CH-1:0][DATA_W-1:0]  tap_rd;
   logic signed [DATA_W-1:0]     x_sel;
   logic signed [COEF_W-1:0]     c_sel;
   logic signed [PROD_W-1:0]     prod;
   logic [DATA_W-1:0]            res;
   logic                         accept, ch_ok, last_tap;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_OUT);
   assign accept    = in_valid && in_ready;
   assign ch_ok     = (32'(in_ch) < N_CH);
   assign last_tap  = (tap_idx == TAP_W'(N_TAP - 1));

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      fir_tap_ram #(.DATA_W(DATA_W), .N_TAP(N_TAP)) u_ram (
         .clk_filter (clk_filter),
         .rst        (rst),
         .push       (accept && ch_ok && (in_ch == CH_W'(g))),
         .push_data  (in_data),
         .rd_idx     (tap_idx),
         .rd_data    (tap_rd[g])
      );
   end

   always_comb begin
      x_sel   = tap_rd[cur_ch];
      c_sel   = coef[tap_idx];
      prod    = PROD_W'(x_sel) * PROD_W'(c_sel);
      acc_nxt = acc + ACC_W'(prod);
   end

   // output formatting works on acc_nxt so the last tap lands directly in out_data
`ifdef FIR_ROUND_SAT_EN
   localparam logic signed [ACC_W:0] RND     = ((ACC_W+1)'(1) << SHIFT) >> 1;
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_W:0] rnd_shift;

   always_comb begin
      rnd_shift = ((ACC_W+1)'(acc_nxt) + RND) >>> SHIFT;
      if (rnd_shift > SAT_MAX)      res = SAT_MAX[DATA_W-1:0];
      else if (rnd_shift < SAT_MIN) res = SAT_MIN[DATA_W-1:0];
      else                          res = rnd_shift[DATA_W-1:0];
   end
`else
   always_comb res = DATA_W'(acc_nxt >>> SHIFT);
`endif

   always_ff @(posedge clk_filter) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept && ch_ok) state_nxt = S_MAC;
         S_MAC:   if (last_tap)        state_nxt = S_OUT;
         S_OUT:   if (out_ready)       state_nxt = S_IDLE;
         default:                      state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_filter) begin
      if (rst) begin
         acc      <= '0;
         tap_idx  <= '0;
         cur_ch   <= '0;
         coef     <= '0;
         out_data <= '0;
         out_ch   <= '0;
         ch_err   <= 1'b0;
      end else begin
         ch_err <= accept && !ch_ok;
         if (coef_we && (state == S_IDLE) && (32'(coef_addr) < N_TAP))
            coef[coef_addr] <= coef_data;
         case (state)
            S_IDLE: if (accept && ch_ok) begin
               cur_ch  <= in_ch;
               tap_idx <= '0;
               acc     <= '0;
            end
            S_MAC: begin
               acc     <= acc_nxt;
               tap_idx <= tap_idx + TAP_W'(1);
               if (last_tap) begin
                  out_data <= res;
                  out_ch   <= cur_ch;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multichannel_fir_engine.sv
// Directed bench for multichannel_fir_engine: two instances (SHIFT=0 and SHIFT=15)
// share stimulus; a behavioural model fills a scoreboard checked on each result.
module tb_multichannel_fir_engine;

   localparam int NT = 8;
   localparam int NC = 5;   // five channels so a 3-bit tag can carry out-of-range 5 and 7

   logic        clk_filter = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, coef_we, out_ready;
   logic [2:0]  in_ch, coef_addr;
   logic [15:0] in_data, coef_data;
   logic        in_ready_a, out_valid_a, ch_err_a;
   logic        in_ready_b, out_valid_b, ch_err_b;
   logic [2:0]  out_ch_a, out_ch_b;
   logic [15:0] out_data_a, out_data_b;

   always #5 clk_filter = ~clk_filter;

   multichannel_fir_engine #(.DATA_W(16), .COEF_W(16), .N_TAP(NT), .N_CH(NC), .SHIFT(0)) dut_a (
      .clk_filter(clk_filter), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
      .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .out_valid(out_valid_a), .out_ready(out_ready),
      .out_ch(out_ch_a), .out_data(out_data_a), .ch_err(ch_err_a));

   multichannel_fir_engine #(.DATA_W(16), .COEF_W(16), .N_TAP(NT), .N_CH(NC), .SHIFT(15)) dut_b (
      .clk_filter(clk_filter), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_ch(out_ch_b), .out_data(out_data_b), .ch_err(ch_err_b));

   typedef struct {
      int          ch;
      logic [15:0] d0;
      logic [15:0] d1;
   } exp_t;

   exp_t        exp_q[$];
   longint      cf[NT];
   longint      xl[NC][NT];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   logic [15:0] last_a, last_b;

   always @(posedge clk_filter) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   function automatic logic [15:0] fmt(input longint acc, input int sh);
      longint r;
`ifdef FIR_ROUND_SAT_EN
      r = (acc + ((longint'(1) << sh) >> 1)) >>> sh;
      if (r > 32767)       r = 32767;
      else if (r < -32768) r = -32768;
`else
      r = acc >>> sh;
`endif
      return r[15:0];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < NT; k++) begin
         cf[k] = 0;
         for (int c = 0; c < NC; c++) xl[c][k] = 0;
      end
      exp_q.delete();
   endtask

   task automatic model_accept(input int ch, input int d);
      logic signed [15:0] ds;
      longint             acc;
      exp_t               e;
      if (ch < NC) begin
         ds = d[15:0];
         for (int k = NT - 1; k > 0; k--) xl[ch][k] = xl[ch][k-1];
         xl[ch][0] = longint'(ds);
         acc = 0;
         for (int k = 0; k < NT; k++) acc += cf[k] * xl[ch][k];
         e.ch = ch;
         e.d0 = fmt(acc, 0);
         e.d1 = fmt(acc, 15);
         exp_q.push_back(e);
      end
   endtask

   task automatic wcoef(input int a, input int v);
      logic signed [15:0] vs;
      vs = v[15:0];
      coef_we = 1'b1; coef_addr = a[2:0]; coef_data = vs;
      @(posedge clk_filter);
      cf[a] = longint'(vs);
      #1 coef_we = 1'b0;
   endtask

   task automatic send(input int ch, input int d, input bit we = 1'b0,
                       input int ca = 0, input int cv = 0);
      logic signed [15:0] cvs;
      cvs = cv[15:0];
      chk("in_ready", in_ready_a, 1);
      in_valid = 1'b1; in_ch = ch[2:0]; in_data = d[15:0];
      coef_we = we; coef_addr = ca[2:0]; coef_data = cvs;
      @(posedge clk_filter);
      if (we) cf[ca] = longint'(cvs);
      model_accept(ch, d);
      #1;
      in_valid = 1'b0; coef_we = 1'b0;
      acc_cyc = cyc;
      chk("ch_err", ch_err_a, (ch >= NC));
   endtask

   task automatic collect(input int hold = 0);
      int   g;
      exp_t e;
      g = 0;
      while (out_valid_a !== 1'b1 && g < 40) begin
         @(posedge clk_filter); #1; g++;
      end
      chk("out_valid", out_valid_a, 1);
      chk("latency", cyc - acc_cyc + 1, NT + 1);
      chk("out_valid_b", out_valid_b, 1);
      chk("sb_size", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("out_ch", out_ch_a, e.ch);
         chk("out_data_s0", out_data_a, e.d0);
         chk("out_data_s15", out_data_b, e.d1);
         last_a = out_data_a;
         last_b = out_data_b;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk_filter); #1;
            chk("hold_valid", out_valid_a, 1);
            chk("hold_data", out_data_a, e.d0);
            chk("hold_in_ready", in_ready_a, 0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk_filter); #1;
      chk("released", out_valid_a, 0);
   endtask

   initial begin
      in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      in_ch = '0; in_data = '0; coef_addr = '0; coef_data = '0;
      model_clear();
      repeat (3) @(posedge clk_filter);
      #1;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_out_data", out_data_a, 0);
      chk("rst_out_ch", out_ch_a, 0);
      chk("rst_ch_err", ch_err_a, 0);
      chk("rst_out_valid_b", out_valid_b, 0);
      rst = 1'b0;
      chk("in_ready_after_rst", in_ready_a, 1);

      // impulse response with c[k] = k+1
      for (int k = 0; k < NT; k++) wcoef(k, k + 1);
      for (int k = 0; k <= NT; k++) begin
         send(0, (k == 0) ? 1 : 0);
         collect();
         chk("impulse", last_a, (k < NT) ? k + 1 : 0);
      end

      // channel isolation
      for (int k = 0; k < NT; k++) wcoef(k, 1);
      send(1, 100); collect(); chk("iso_ch1", last_a, 100);
      send(2, 200); collect(); chk("iso_ch2", last_a, 200);

      // backpressure
      out_ready = 1'b0;
      send(0, 7);
      collect(20);

      // full-scale accumulation
      for (int k = 0; k < NT; k++) wcoef(k, 32767);
      repeat (NT) begin send(0, 32767); collect(); end
`ifdef FIR_ROUND_SAT_EN
      chk("sat_shift15", last_b, 16'h7fff);
      chk("sat_shift0", last_a, 16'h7fff);
`else
      chk("wrap_shift15", last_b, 16'hfff0);
      chk("wrap_shift0", last_a, 16'h0008);
`endif

      // out-of-range channel tags
      send(5, 123);
      @(posedge clk_filter); #1;
      chk("ch_err_pulse_end", ch_err_a, 0);
      for (int i = 0; i < 12; i++) begin
         chk("err_no_out", out_valid_a, 0);
         @(posedge clk_filter); #1;
      end
      chk("err_idle", in_ready_a, 1);
      send(7, 9);
      repeat (12) begin @(posedge clk_filter); #1; end
      chk("err7_no_out", out_valid_a, 0);

      // reset during the third MAC cycle
      send(1, 55);
      repeat (2) begin @(posedge clk_filter); #1; end
      rst = 1'b1;
      @(posedge clk_filter); #1;
      rst = 1'b0;
      model_clear();
      chk("abort_idle", in_ready_a, 1);
      for (int i = 0; i < 15; i++) begin
         chk("abort_no_out", out_valid_a, 0);
         @(posedge clk_filter); #1;
      end
      send(3, 5); collect(); chk("coef_cleared", last_a, 0);
      for (int k = 0; k < NT; k++) wcoef(k, k + 1);
      for (int k = 0; k < 3; k++) begin
         send(0, (k == 0) ? 1 : 0);
         collect();
         chk("impulse_after_rst", last_a, k + 1);
      end

      // coefficient write gating
      send(2, 10);
      coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd50;
      @(posedge clk_filter); #1;
      coef_we = 1'b0;
      collect(); chk("gate_mac_result", last_a, 10);
      send(2, 3); collect(); chk("gate_coef_kept", last_a, 23);
      send(2, 4, 1'b1, 0, 9); collect(); chk("gate_same_cycle", last_a, 72);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
